// File: rtl/disp_pkg.sv
// Shared types, segment patterns and helpers for the two-digit BCD display.
package disp_pkg;

   typedef enum logic {IDLE = 1'b0, CONV = 1'b1} conv_state_t;

   // Logical segment patterns {g,f,e,d,c,b,a}, 1 = lit, before pin polarity.
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // BCD digit to logical segment pattern; non-decimal codes stay dark.
   function automatic logic [6:0] seg7_of(input logic [3:0] d);
      case (d)
         4'd0:    seg7_of = SEG_0;
         4'd1:    seg7_of = SEG_1;
         4'd2:    seg7_of = SEG_2;
         4'd3:    seg7_of = SEG_3;
         4'd4:    seg7_of = SEG_4;
         4'd5:    seg7_of = SEG_5;
         4'd6:    seg7_of = SEG_6;
         4'd7:    seg7_of = SEG_7;
         4'd8:    seg7_of = SEG_8;
         4'd9:    seg7_of = SEG_9;
         default: seg7_of = SEG_BLANK;
      endcase
   endfunction

   // Double-dabble correction: a nibble of 5 or more gets 3 added before the shift.
   function automatic logic [3:0] add3_if_ge5(input logic [3:0] n);
      add3_if_ge5 = (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

endpackage

// File: rtl/bcd_7seg_display_if.sv
// Display bus: binary value in, multiplexed segment/anode pins and busy out.
// busy is a status level, not a handshake: it is high exactly while a
// conversion is running; value may change at any time and is re-sampled
// whenever the converter is idle and value differs from what is displayed.
interface bcd_7seg_display_if;
   logic [5:0] value;
   logic [6:0] seg;
   logic       dp;
   logic [1:0] an;
   logic       busy;

   modport master (output value, input seg, dp, an, busy);
   modport slave  (input value, output seg, dp, an, busy);
endinterface

// File: rtl/bcd_7seg_display_seg7_decode.sv
// Combinational BCD digit to logical 7-segment pattern (polarity applied by the caller).
module seg7_decode
   import disp_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   // Pure table lookup.
   always_comb seg_o = seg7_of(bcd_i);

endmodule

// File: rtl/bcd_7seg_display.sv
// Two-digit multiplexed 7-segment display of a 6-bit binary value.
// A serial double-dabble FSM converts to BCD one bit per clock; a scan
// divider alternates the digit anodes with a one-cycle blank at each switch.
module bcd_7seg_display
   import disp_pkg::*;
#(
   parameter int unsigned F_CLK_HZ           = 25_000_000,
   parameter int unsigned SCAN_HZ            = 1000,
   parameter bit          SEG_ACTIVE_LOW     = 1'b1,
   parameter bit          AN_ACTIVE_LOW      = 1'b1,
   parameter bit          BLANK_LEADING_ZERO = 1'b1
)(
   input  logic                     clk,
   input  logic                     reset_n,
   bcd_7seg_display_if.slave        bus,
   output conv_state_t              dbg_state_o
);

   localparam int unsigned SCAN_RAW = F_CLK_HZ / SCAN_HZ;
   localparam int unsigned SCAN_TKS = (SCAN_RAW < 2) ? 2 : SCAN_RAW;
   localparam int          CNT_W    = $clog2(SCAN_TKS);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_TKS - 1);

   conv_state_t       state_q, state_d;
   logic [5:0]        shreg_q, cap_q, shown_q;
   logic [7:0]        bcd_q;
   logic [2:0]        bitcnt_q;
   logic [3:0]        tens_q, ones_q;
   logic [13:0]       shift_all;

   logic [CNT_W-1:0]  scan_cnt_q;
   logic              digit_sel_q;
   logic              wrap;
   logic              lit;
   logic [3:0]        digit_bcd;
   logic [6:0]        digit_seg;
   logic [6:0]        seg_d, seg_q;
   logic [1:0]        an_d, an_q;
   logic              dp_q;

   // Conversion state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state: start on a mismatch, finish after the sixth shift.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.value != shown_q) state_d = CONV;
         CONV:    if (bitcnt_q == 3'd1)     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: busy tracks the CONV state directly (it is a flop).
   always_comb begin
      bus.busy    = (state_q == CONV);
      dbg_state_o = state_q;
   end

   // One double-dabble step: correct both nibbles, then shift {bcd,shreg} left.
   always_comb begin
      shift_all = {add3_if_ge5(bcd_q[7:4]), add3_if_ge5(bcd_q[3:0]), shreg_q} << 1;
   end

   // Conversion datapath; tens/ones/shown_bin update together on the last shift.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg_q  <= '0;
         cap_q    <= '0;
         shown_q  <= '0;
         bcd_q    <= '0;
         bitcnt_q <= '0;
         tens_q   <= '0;
         ones_q   <= '0;
      end else if (state_q == IDLE) begin
         if (state_d == CONV) begin
            shreg_q  <= bus.value;
            cap_q    <= bus.value;
            bcd_q    <= '0;
            bitcnt_q <= 3'd6;
         end
      end else begin
         bcd_q    <= shift_all[13:6];
         shreg_q  <= shift_all[5:0];
         bitcnt_q <= bitcnt_q - 3'd1;
         if (bitcnt_q == 3'd1) begin
            tens_q  <= shift_all[13:10];
            ones_q  <= shift_all[9:6];
            shown_q <= cap_q;
         end
      end
   end

   assign wrap = (scan_cnt_q == SCAN_LAST);

   // Scan divider: free-running, flips the selected digit on each wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scan_cnt_q  <= '0;
         digit_sel_q <= 1'b0;
      end else if (wrap) begin
         scan_cnt_q  <= '0;
         digit_sel_q <= ~digit_sel_q;
      end else begin
         scan_cnt_q  <= scan_cnt_q + 1'b1;
      end
   end

   assign digit_bcd = digit_sel_q ? tens_q : ones_q;

   seg7_decode u_decode (
      .bcd_i (digit_bcd),
      .seg_o (digit_seg)
   );

   // Pin pattern: dark on the wrap cycle and for a suppressed leading zero.
   always_comb begin
      lit   = !wrap && !(digit_sel_q && (tens_q == 4'd0) && BLANK_LEADING_ZERO);
      an_d  = 2'b00;
      seg_d = SEG_BLANK;
      if (lit) begin
         an_d  = digit_sel_q ? 2'b10 : 2'b01;
         seg_d = digit_seg;
      end
   end

   // Registered pins with polarity applied; reset leaves everything dark.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seg_q <= SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
         an_q  <= AN_ACTIVE_LOW  ? 2'b11 : 2'b00;
         dp_q  <= SEG_ACTIVE_LOW;
      end else begin
         seg_q <= SEG_ACTIVE_LOW ? ~seg_d : seg_d;
         an_q  <= AN_ACTIVE_LOW  ? ~an_d  : an_d;
         dp_q  <= SEG_ACTIVE_LOW;
      end
   end

   assign bus.seg = seg_q;
   assign bus.an  = an_q;
   assign bus.dp  = dp_q;

endmodule
